// File: rtl/mem_bus_ctrl_if.sv
// Core-side request/response ports and byte-serial host bus of mem_bus_ctrl.
// The master modport is the controller's view; slave is the core/host side.
interface mem_bus_ctrl_if;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        fetch_done;
    logic [15:0] instr_word0;
    logic [15:0] instr_word1;
    logic        instr_has_ext;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_done;
    logic [15:0] mem_rdata;
    logic        halt_req;
    logic [7:0]  out_bus;
    logic [7:0]  in_bus;
    logic        bus_pc;
    logic        bus_mar;
    logic        bus_mdr;
    logic        ard_data_ready;
    logic        ard_receive_ready;
    logic        halt;
    logic        busy;

    modport master (
        input  fetch_req, fetch_addr, mem_req, mem_we, mem_addr, mem_wdata, halt_req,
               in_bus, ard_data_ready, ard_receive_ready,
        output fetch_done, instr_word0, instr_word1, instr_has_ext, mem_done, mem_rdata,
               out_bus, bus_pc, bus_mar, bus_mdr, halt, busy
    );

    modport slave (
        output fetch_req, fetch_addr, mem_req, mem_we, mem_addr, mem_wdata, halt_req,
               in_bus, ard_data_ready, ard_receive_ready,
        input  fetch_done, instr_word0, instr_word1, instr_has_ext, mem_done, mem_rdata,
               out_bus, bus_pc, bus_mar, bus_mdr, halt, busy
    );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Byte-serial memory bus controller: arbitrates fetch/load-store/halt, serializes
// addresses and store data onto the host bus and reassembles returned bytes into words.
module mem_bus_ctrl #(
    parameter logic [3:0] I_TYPE_CODE = 4'h1,
    parameter logic [3:0] M_TYPE_CODE = 4'h2
) (
    input  logic           clock,
    input  logic           reset,
    mem_bus_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, ADDR_LO, ADDR_HI, WDATA_LO, WDATA_HI,
        RDATA_LO, RDATA_HI, EXT_LO, EXT_HI, HALTED
    } state_t;

    typedef enum logic [1:0] {OP_FETCH, OP_LOAD, OP_STORE} op_t;

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [7:0]  lo_q, lo_d;
    logic [15:0] word0_q, word0_d;

    logic        fetch_done_q, fetch_done_d;
    logic        mem_done_q, mem_done_d;
    logic [15:0] instr_word0_q, instr_word0_d;
    logic [15:0] instr_word1_q, instr_word1_d;
    logic        instr_has_ext_q, instr_has_ext_d;
    logic [15:0] mem_rdata_q, mem_rdata_d;
    logic [7:0]  out_bus_q, out_bus_d;
    logic        bus_pc_q, bus_pc_d;
    logic        bus_mar_q, bus_mar_d;
    logic        bus_mdr_q, bus_mdr_d;
    logic        halt_q, halt_d;
    logic        busy_q, busy_d;

    logic        accept;
    logic        is_ext_type;

    // A done pulse blocks acceptance so the requester can drop its req first.
    assign accept = (state_q == IDLE) && bus.ard_receive_ready && !fetch_done_q && !mem_done_q;
    assign is_ext_type = (lo_q[3:0] == I_TYPE_CODE) || (lo_q[3:0] == M_TYPE_CODE);

    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        lo_d            = lo_q;
        word0_d         = word0_q;
        fetch_done_d    = 1'b0;
        mem_done_d      = 1'b0;
        instr_word0_d   = instr_word0_q;
        instr_word1_d   = instr_word1_q;
        instr_has_ext_d = instr_has_ext_q;
        mem_rdata_d     = mem_rdata_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.halt_req) begin
                        state_d = HALTED;
                    end else if (bus.mem_req) begin
                        state_d = ADDR_LO;
                        op_d    = bus.mem_we ? OP_STORE : OP_LOAD;
                        addr_d  = bus.mem_addr;
                        wdata_d = bus.mem_wdata;
                    end else if (bus.fetch_req) begin
                        state_d = ADDR_LO;
                        op_d    = OP_FETCH;
                        addr_d  = bus.fetch_addr;
                    end
                end
            end
            ADDR_LO:  state_d = ADDR_HI;
            ADDR_HI:  state_d = (op_q == OP_STORE) ? WDATA_LO : RDATA_LO;
            WDATA_LO: state_d = WDATA_HI;
            WDATA_HI: begin
                state_d    = IDLE;
                mem_done_d = 1'b1;
            end
            RDATA_LO: begin
                if (bus.ard_data_ready) begin
                    lo_d    = bus.in_bus;
                    state_d = RDATA_HI;
                end
            end
            RDATA_HI: begin
                if (bus.ard_data_ready) begin
                    if (op_q == OP_LOAD) begin
                        mem_rdata_d = {bus.in_bus, lo_q};
                        mem_done_d  = 1'b1;
                        state_d     = IDLE;
                    end else if (is_ext_type) begin
                        word0_d = {bus.in_bus, lo_q};
                        state_d = EXT_LO;
                    end else begin
                        instr_word0_d   = {bus.in_bus, lo_q};
                        instr_word1_d   = 16'h0000;
                        instr_has_ext_d = 1'b0;
                        fetch_done_d    = 1'b1;
                        state_d         = IDLE;
                    end
                end
            end
            EXT_LO: begin
                if (bus.ard_data_ready) begin
                    lo_d    = bus.in_bus;
                    state_d = EXT_HI;
                end
            end
            EXT_HI: begin
                if (bus.ard_data_ready) begin
                    instr_word0_d   = word0_q;
                    instr_word1_d   = {bus.in_bus, lo_q};
                    instr_has_ext_d = 1'b1;
                    fetch_done_d    = 1'b1;
                    state_d         = IDLE;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
        endcase

        // Bus outputs are registered, so they are decoded from the state being entered.
        out_bus_d = 8'h00;
        bus_pc_d  = 1'b0;
        bus_mar_d = 1'b0;
        bus_mdr_d = 1'b0;
        case (state_d)
            ADDR_LO, ADDR_HI: begin
                out_bus_d = (state_d == ADDR_LO) ? addr_d[7:0] : addr_d[15:8];
                bus_pc_d  = (op_d == OP_FETCH);
                bus_mar_d = (op_d != OP_FETCH);
                bus_mdr_d = (op_d == OP_STORE);
            end
            WDATA_LO, WDATA_HI: begin
                out_bus_d = (state_d == WDATA_LO) ? wdata_d[7:0] : wdata_d[15:8];
                bus_mdr_d = 1'b1;
            end
            default: begin
                out_bus_d = 8'h00;
            end
        endcase

        busy_d = (state_d != IDLE) && (state_d != HALTED);
        halt_d = (state_d == HALTED);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            op_q            <= OP_FETCH;
            addr_q          <= 16'h0000;
            wdata_q         <= 16'h0000;
            lo_q            <= 8'h00;
            word0_q         <= 16'h0000;
            fetch_done_q    <= 1'b0;
            mem_done_q      <= 1'b0;
            instr_word0_q   <= 16'h0000;
            instr_word1_q   <= 16'h0000;
            instr_has_ext_q <= 1'b0;
            mem_rdata_q     <= 16'h0000;
            out_bus_q       <= 8'h00;
            bus_pc_q        <= 1'b0;
            bus_mar_q       <= 1'b0;
            bus_mdr_q       <= 1'b0;
            halt_q          <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            op_q            <= op_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            lo_q            <= lo_d;
            word0_q         <= word0_d;
            fetch_done_q    <= fetch_done_d;
            mem_done_q      <= mem_done_d;
            instr_word0_q   <= instr_word0_d;
            instr_word1_q   <= instr_word1_d;
            instr_has_ext_q <= instr_has_ext_d;
            mem_rdata_q     <= mem_rdata_d;
            out_bus_q       <= out_bus_d;
            bus_pc_q        <= bus_pc_d;
            bus_mar_q       <= bus_mar_d;
            bus_mdr_q       <= bus_mdr_d;
            halt_q          <= halt_d;
            busy_q          <= busy_d;
        end
    end

    assign bus.fetch_done    = fetch_done_q;
    assign bus.mem_done      = mem_done_q;
    assign bus.instr_word0   = instr_word0_q;
    assign bus.instr_word1   = instr_word1_q;
    assign bus.instr_has_ext = instr_has_ext_q;
    assign bus.mem_rdata     = mem_rdata_q;
    assign bus.out_bus       = out_bus_q;
    assign bus.bus_pc        = bus_pc_q;
    assign bus.bus_mar       = bus_mar_q;
    assign bus.bus_mdr       = bus_mdr_q;
    assign bus.halt          = halt_q;
    assign bus.busy          = busy_q;
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: a scoreboard of expected bus beats, host bytes and
// done results is filled when a request is raised and drained as the DUT responds.
module tb_mem_bus_ctrl;
    localparam logic [3:0] I_TYPE = 4'h1;
    localparam logic [3:0] M_TYPE = 4'h2;

    typedef struct packed {
        logic [7:0] data;
        logic       pc;
        logic       mar;
        logic       mdr;
    } beat_t;

    typedef struct {
        logic        isFetch;
        logic        isStore;
        logic [15:0] w0;
        logic [15:0] w1;
        logic        ext;
        logic [15:0] rdata;
        int          latency;
    } result_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    mem_bus_ctrl_if bus ();

    mem_bus_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    beat_t      beatQ[$];
    logic [7:0] respQ[$];
    result_t    resQ[$];

    int   gapCycles = 0;
    int   gapCnt = 0;
    logic inTxn = 1'b0;
    int   acceptCyc = 0;
    int   lastDoneCyc = 0;
    int   lastGap = 0;
    logic haltArm = 1'b0;
    int   resetArm = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic beat_t mkBeat(input logic [7:0] d, input logic pc, input logic mar, input logic mdr);
        beat_t b;
        b.data = d;
        b.pc   = pc;
        b.mar  = mar;
        b.mdr  = mdr;
        return b;
    endfunction

    // kind: 0 = fetch, 1 = load, 2 = store. w0/w1 are the words the host will return.
    task automatic applyStimulus(input int kind, input logic [15:0] addr, input logic [15:0] wdata,
                                 input logic [15:0] w0, input logic [15:0] w1, input int gap);
        result_t r;
        logic    ext;
        ext       = (kind == 0) && ((w0[3:0] == I_TYPE) || (w0[3:0] == M_TYPE));
        r.isFetch = (kind == 0);
        r.isStore = (kind == 2);
        r.w0      = w0;
        r.w1      = ext ? w1 : 16'h0000;
        r.ext     = ext;
        r.rdata   = w0;
        beatQ.push_back(mkBeat(addr[7:0], kind == 0, kind != 0, kind == 2));
        beatQ.push_back(mkBeat(addr[15:8], kind == 0, kind != 0, kind == 2));
        if (kind == 2) begin
            beatQ.push_back(mkBeat(wdata[7:0], 1'b0, 1'b0, 1'b1));
            beatQ.push_back(mkBeat(wdata[15:8], 1'b0, 1'b0, 1'b1));
            r.latency = 5;
        end else begin
            respQ.push_back(w0[7:0]);
            respQ.push_back(w0[15:8]);
            r.latency = 5 + 2 * gap;
            if (ext) begin
                respQ.push_back(w1[7:0]);
                respQ.push_back(w1[15:8]);
                r.latency = 7 + 4 * gap;
            end
        end
        resQ.push_back(r);
        gapCycles = gap;
        gapCnt    = gap;
        if (kind == 0) begin
            bus.fetch_addr = addr;
            bus.fetch_req  = 1'b1;
        end else begin
            bus.mem_addr  = addr;
            bus.mem_wdata = wdata;
            bus.mem_we    = (kind == 2);
            bus.mem_req   = 1'b1;
        end
    endtask

    task automatic runCycles(input int budget);
        int         n;
        logic [2:0] strobes;
        beat_t      b;
        result_t    r;
        n = 0;
        while (resQ.size() > 0) begin
            @(posedge clock);
            #1;
            n++;
            if (n > budget) begin
                checkOutput("timeout_pending", 32'(resQ.size()), 32'h0);
                resQ.delete();
                respQ.delete();
                beatQ.delete();
                inTxn = 1'b0;
                break;
            end
            strobes = {bus.bus_pc, bus.bus_mar, bus.bus_mdr};
            checkOutput("halt_low", 32'(bus.halt), 32'h0);
            if (strobes != 3'b000) begin
                if (!inTxn) begin
                    inTxn     = 1'b1;
                    acceptCyc = cyc - 1;
                    lastGap   = acceptCyc - lastDoneCyc;
                end
                if (beatQ.size() == 0) begin
                    checkOutput("unexpected_beat", 32'(strobes), 32'h0);
                end else begin
                    b = beatQ.pop_front();
                    checkOutput("beat", 32'({bus.out_bus, strobes}), 32'(b));
                end
            end else begin
                checkOutput("idle_out_bus", 32'(bus.out_bus), 32'h0);
            end
            if (bus.fetch_done || bus.mem_done) begin
                r = resQ.pop_front();
                checkOutput("done_kind", 32'({bus.fetch_done, bus.mem_done}), r.isFetch ? 32'h2 : 32'h1);
                if (r.isFetch) begin
                    checkOutput("instr_word0", 32'(bus.instr_word0), 32'(r.w0));
                    checkOutput("instr_word1", 32'(bus.instr_word1), 32'(r.w1));
                    checkOutput("instr_has_ext", 32'(bus.instr_has_ext), 32'(r.ext));
                end else if (!r.isStore) begin
                    checkOutput("mem_rdata", 32'(bus.mem_rdata), 32'(r.rdata));
                end
                checkOutput("done_latency", 32'(cyc - acceptCyc), 32'(r.latency));
                checkOutput("busy_at_done", 32'(bus.busy), 32'h0);
                if (r.isFetch) bus.fetch_req = 1'b0;
                else bus.mem_req = 1'b0;
                inTxn       = 1'b0;
                lastDoneCyc = cyc;
            end else if (inTxn) begin
                checkOutput("busy", 32'(bus.busy), 32'h1);
            end
            if (haltArm && inTxn && (cyc - acceptCyc) == 3) begin
                bus.halt_req = 1'b1;
                haltArm      = 1'b0;
            end
            if (resetArm > 0 && inTxn && (cyc - acceptCyc) == resetArm) begin
                resetArm              = 0;
                reset                 = 1'b1;
                bus.fetch_req         = 1'b0;
                bus.ard_receive_ready = 1'b0;
                bus.ard_data_ready    = 1'b0;
                resQ.delete();
                respQ.delete();
                beatQ.delete();
                inTxn = 1'b0;
                break;
            end
            bus.ard_data_ready = 1'b0;
            bus.in_bus         = 8'($urandom);
            if (inTxn && bus.busy && strobes == 3'b000 && respQ.size() > 0) begin
                if (gapCnt > 0) begin
                    gapCnt--;
                end else begin
                    bus.ard_data_ready = 1'b1;
                    bus.in_bus         = respQ.pop_front();
                    gapCnt             = gapCycles;
                end
            end
        end
        checkOutput("beats_left", 32'(beatQ.size()), 32'h0);
    endtask

    task automatic idleCycles(input int n, input logic expHalt);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            checkOutput("idle_strobes", 32'({bus.bus_pc, bus.bus_mar, bus.bus_mdr}), 32'h0);
            checkOutput("idle_bus", 32'(bus.out_bus), 32'h0);
            checkOutput("idle_busy", 32'(bus.busy), 32'h0);
            checkOutput("idle_halt", 32'(bus.halt), 32'(expHalt));
        end
    endtask

    task automatic checkResetState();
        checkOutput("rst_out_bus", 32'(bus.out_bus), 32'h0);
        checkOutput("rst_strobes", 32'({bus.bus_pc, bus.bus_mar, bus.bus_mdr}), 32'h0);
        checkOutput("rst_halt", 32'(bus.halt), 32'h0);
        checkOutput("rst_busy", 32'(bus.busy), 32'h0);
        checkOutput("rst_done", 32'({bus.fetch_done, bus.mem_done}), 32'h0);
        checkOutput("rst_word0", 32'(bus.instr_word0), 32'h0);
        checkOutput("rst_word1", 32'(bus.instr_word1), 32'h0);
        checkOutput("rst_has_ext", 32'(bus.instr_has_ext), 32'h0);
        checkOutput("rst_rdata", 32'(bus.mem_rdata), 32'h0);
    endtask

    initial begin
        bus.fetch_req         = 1'b0;
        bus.fetch_addr        = 16'h0000;
        bus.mem_req           = 1'b0;
        bus.mem_we            = 1'b0;
        bus.mem_addr          = 16'h0000;
        bus.mem_wdata         = 16'h0000;
        bus.halt_req          = 1'b0;
        bus.in_bus            = 8'h00;
        bus.ard_data_ready    = 1'b0;
        bus.ard_receive_ready = 1'b0;
        reset                 = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checkResetState();
        reset                 = 1'b0;
        bus.ard_receive_ready = 1'b1;

        $display("[TB] R-type fetch");
        applyStimulus(0, 16'h0004, 16'h0000, 16'h4A30, 16'hDEAD, 0);
        runCycles(40);

        $display("[TB] I-type fetch with data-ready gaps");
        applyStimulus(0, 16'h0006, 16'h0000, 16'h1041, 16'h0005, 3);
        runCycles(80);

        $display("[TB] store");
        applyStimulus(2, 16'h0004, 16'h000B, 16'h0000, 16'h0000, 0);
        runCycles(40);

        $display("[TB] simultaneous load and fetch");
        bus.ard_receive_ready = 1'b0;
        applyStimulus(1, 16'h0030, 16'h0000, 16'h000B, 16'h0000, 0);
        applyStimulus(0, 16'h0008, 16'h0000, 16'h2002, 16'h0010, 0);
        idleCycles(4, 1'b0);
        bus.ard_receive_ready = 1'b1;
        runCycles(60);
        checkOutput("fetch_gap_after_load", 32'(lastGap), 32'd1);

        $display("[TB] reset during EXT_LO");
        resetArm = 5;
        applyStimulus(0, 16'h000A, 16'h0000, 16'h3011, 16'h1234, 0);
        runCycles(40);
        resetArm = 0;
        @(posedge clock);
        #1;
        checkResetState();
        reset                 = 1'b0;
        bus.ard_receive_ready = 1'b1;
        applyStimulus(0, 16'h000C, 16'h0000, 16'h5672, 16'hBEEF, 0);
        runCycles(40);

        $display("[TB] halt during RDATA_LO");
        haltArm = 1'b1;
        applyStimulus(0, 16'h000E, 16'h0000, 16'h7A00, 16'h0000, 3);
        runCycles(60);
        @(posedge clock);
        #1;
        checkOutput("halt_before_accept", 32'(bus.halt), 32'h0);
        @(posedge clock);
        #1;
        checkOutput("halt_after_accept", 32'(bus.halt), 32'h1);
        checkOutput("halt_busy", 32'(bus.busy), 32'h0);
        bus.halt_req   = 1'b0;
        bus.fetch_addr = 16'h0020;
        bus.fetch_req  = 1'b1;
        bus.mem_addr   = 16'h0040;
        bus.mem_we     = 1'b1;
        bus.mem_req    = 1'b1;
        idleCycles(6, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog");
    end
endmodule
